// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types, strobe constants and alignment rule for mem_arbiter
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_D    = 2'd1,
    OWN_I    = 2'd2
  } owner_t;

  localparam logic [3:0] WSTRB_READ = 4'h0;
  localparam logic [3:0] WSTRB_WORD = 4'hF;
  localparam logic [3:0] WSTRB_HALF_LO = 4'h3;
  localparam logic [3:0] WSTRB_HALF_HI = 4'hC;

  // Word reads/writes need a 4-byte aligned address, halfword strobes a 2-byte one.
  function automatic logic is_misaligned(input logic [1:0] lsb, input logic [3:0] wstrb);
    logic bad;
    bad = 1'b0;
    if (wstrb == WSTRB_READ || wstrb == WSTRB_WORD) begin
      bad = (lsb != 2'b00);
    end else if (wstrb == WSTRB_HALF_LO || wstrb == WSTRB_HALF_HI) begin
      bad = lsb[0];
    end
    return bad;
  endfunction

endpackage

// File: rtl/mem_arbiter_starve_ctr.sv
// rtl/mem_arbiter_starve_ctr.sv - saturating count of data wins while fetch waits
module mem_arbiter_starve_ctr #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic ck_rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);

  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Clear wins over increment; increment stops at MAX.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != W'(MAX))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter state register.
  always_ff @(posedge clk or negedge ck_rst) begin
    if (!ck_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat_o = (cnt_q == W'(MAX));

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/load-store arbiter for the shared BRAM (optional MEM_ARBITER_ALIGN_CHECK_EN)
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              ck_rst,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [3:0]        d_req_wstrb,
  input  logic [DATA_W-1:0] d_req_wdata,
  output logic              d_resp_valid,
  output logic [DATA_W-1:0] d_resp_rdata,
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_resp_valid,
  output logic [DATA_W-1:0] i_resp_rdata,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-3:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              err_misalign
);

  logic        sat;
  logic        fetch_win;
  logic        data_win;
  logic        i_fire;
  logic        d_fire;
  logic        d_misalign;
  logic        d_ram_fire;
  owner_t      owner_d;
  owner_t      owner_q;
  logic        err_d;
  logic        err_q;
  logic [DATA_W-1:0] d_rdata_now;
  logic [DATA_W-1:0] d_rdata_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic        unused_addr_lsbs;

  assign unused_addr_lsbs = ^{i_req_addr[1:0], d_req_addr[1:0]};

`ifdef MEM_ARBITER_ALIGN_CHECK_EN
  assign d_misalign = is_misaligned(d_req_addr[1:0], d_req_wstrb);
`else
  assign d_misalign = 1'b0;
`endif

  // Fixed data priority, except fetch takes one slot once the starvation count saturates.
  always_comb begin
    fetch_win = ck_rst && i_req_valid && (!d_req_valid || sat);
    data_win  = ck_rst && d_req_valid && !fetch_win;
  end

  assign i_req_ready = fetch_win;
  assign d_req_ready = data_win;
  assign i_fire      = i_req_valid && i_req_ready;
  assign d_fire      = d_req_valid && d_req_ready;
  // A misaligned data access is acknowledged but never reaches the BRAM.
  assign d_ram_fire  = d_fire && !d_misalign;

  // BRAM drive follows the winner of this cycle.
  always_comb begin
    ram_en    = i_fire || d_ram_fire;
    ram_we    = d_ram_fire ? d_req_wstrb : 4'h0;
    ram_addr  = i_fire ? i_req_addr[ADDR_W-1:2] : d_req_addr[ADDR_W-1:2];
    ram_wdata = d_req_wdata;
  end

  // Tag the cycle's grant so next cycle's BRAM data is routed to its owner.
  always_comb begin
    owner_d = OWN_NONE;
    if (i_fire) begin
      owner_d = OWN_I;
    end else if (d_fire) begin
      owner_d = OWN_D;
    end
    err_d = d_fire && d_misalign;
  end

  mem_arbiter_starve_ctr #(
    .MAX(STARVE_MAX)
  ) u_starve_ctr (
    .clk   (clk),
    .ck_rst(ck_rst),
    .inc_i (d_fire && i_req_valid),
    .clr_i (i_fire || !i_req_valid),
    .sat_o (sat)
  );

  assign d_rdata_now = err_q ? '0 : ram_rdata;

  // Response owner and hold registers; the non-owner keeps its last delivered word.
  always_ff @(posedge clk or negedge ck_rst) begin
    if (!ck_rst) begin
      owner_q   <= OWN_NONE;
      err_q     <= 1'b0;
      d_rdata_q <= '0;
      i_rdata_q <= '0;
    end else begin
      owner_q <= owner_d;
      err_q   <= err_d;
      if (owner_q == OWN_D) begin
        d_rdata_q <= d_rdata_now;
      end
      if (owner_q == OWN_I) begin
        i_rdata_q <= ram_rdata;
      end
    end
  end

  assign d_resp_valid = (owner_q == OWN_D);
  assign i_resp_valid = (owner_q == OWN_I);
  assign d_resp_rdata = (owner_q == OWN_D) ? d_rdata_now : d_rdata_q;
  assign i_resp_rdata = (owner_q == OWN_I) ? ram_rdata : i_rdata_q;
  assign err_misalign = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with BRAM and reference model
module tb_mem_arbiter;

  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              ck_rst;
  logic              d_req_valid;
  logic              d_req_ready;
  logic [ADDR_W-1:0] d_req_addr;
  logic [3:0]        d_req_wstrb;
  logic [DATA_W-1:0] d_req_wdata;
  logic              d_resp_valid;
  logic [DATA_W-1:0] d_resp_rdata;
  logic              i_req_valid;
  logic              i_req_ready;
  logic [ADDR_W-1:0] i_req_addr;
  logic              i_resp_valid;
  logic [DATA_W-1:0] i_resp_rdata;
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [ADDR_W-3:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              err_misalign;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk         (clk),
    .ck_rst      (ck_rst),
    .d_req_valid (d_req_valid),
    .d_req_ready (d_req_ready),
    .d_req_addr  (d_req_addr),
    .d_req_wstrb (d_req_wstrb),
    .d_req_wdata (d_req_wdata),
    .d_resp_valid(d_resp_valid),
    .d_resp_rdata(d_resp_rdata),
    .i_req_valid (i_req_valid),
    .i_req_ready (i_req_ready),
    .i_req_addr  (i_req_addr),
    .i_resp_valid(i_resp_valid),
    .i_resp_rdata(i_resp_rdata),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .err_misalign(err_misalign)
  );

  function automatic logic [31:0] init_word(input int idx);
    if (idx == 'h10) return 32'h0050_0093;
    return 32'hA5A5_0000 ^ (idx * 32'h0001_0203);
  endfunction

  // Synchronous-read BRAM, read-first, preloaded on its first clock.
  logic [31:0] bram [256];
  logic        loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int k = 0; k < 256; k++) bram[k] <= init_word(k);
      loaded <= 1'b1;
    end else if (ram_en) begin
      ram_rdata <= bram[ram_addr[7:0]];
      for (int b = 0; b < 4; b++) begin
        if (ram_we[b]) bram[ram_addr[7:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
  end

  // Reference model state: memory image, streak of data wins, and the response owed next cycle.
  logic [31:0] ref_mem [256];
  int          streak;
  int          pend_own;      // 0 none, 1 data, 2 fetch
  logic        pend_chk;
  logic [31:0] pend_data;
  logic        pend_err;
  logic [31:0] exp_i_hold;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic misaligned(input logic [15:0] a, input logic [3:0] ws);
`ifdef MEM_ARBITER_ALIGN_CHECK_EN
    if ((ws == 4'h0 || ws == 4'hF) && (a % 4 != 0)) return 1'b1;
    if ((ws == 4'h3 || ws == 4'hC) && (a % 2 == 1)) return 1'b1;
    return 1'b0;
`else
    return (a == 16'hFFFF) && (ws == 4'h5) && 1'b0;
`endif
  endfunction

  task automatic cycle(input logic dv, input logic iv, input logic [15:0] da, input logic [3:0] ws,
                       input logic [31:0] wd, input logic [15:0] ia);
    logic ef, ed, mis;
    int   w;
    @(negedge clk);
    d_req_valid = dv; d_req_addr = da; d_req_wstrb = ws; d_req_wdata = wd;
    i_req_valid = iv; i_req_addr = ia;
    #1;
    chk("d_resp_valid", {31'd0, d_resp_valid}, {31'd0, pend_own == 1});
    chk("i_resp_valid", {31'd0, i_resp_valid}, {31'd0, pend_own == 2});
    chk("err_misalign", {31'd0, err_misalign}, {31'd0, pend_err});
    if (pend_own == 2) begin
      chk("i_resp_rdata", i_resp_rdata, pend_data);
      exp_i_hold = pend_data;
    end else begin
      chk("i_rdata_hold", i_resp_rdata, exp_i_hold);
    end
    if (pend_own == 1 && pend_chk) chk("d_resp_rdata", d_resp_rdata, pend_data);

    ef  = iv && (!dv || streak == STARVE_MAX);
    ed  = dv && !ef;
    mis = ed && misaligned(da, ws);
    chk("i_req_ready", {31'd0, i_req_ready}, {31'd0, ef});
    chk("d_req_ready", {31'd0, d_req_ready}, {31'd0, ed});
    chk("both_ready", {31'd0, d_req_ready & i_req_ready}, 32'd0);
    chk("ram_en", {31'd0, ram_en}, {31'd0, ef || (ed && !mis)});
    chk("ram_we", {28'd0, ram_we}, (ed && !mis) ? {28'd0, ws} : 32'd0);
    if (ef) chk("ram_addr_i", {18'd0, ram_addr}, {18'd0, ia / 4});
    else if (ed && !mis) chk("ram_addr_d", {18'd0, ram_addr}, {18'd0, da / 4});

    pend_own = 0; pend_chk = 1'b0; pend_err = 1'b0; pend_data = 32'd0;
    if (ef) begin
      pend_own = 2; pend_chk = 1'b1; pend_data = ref_mem[(ia / 4) % 256];
    end else if (ed) begin
      pend_own = 1;
      if (mis) begin
        pend_chk = 1'b1; pend_err = 1'b1; pend_data = 32'd0;
      end else begin
        w = (da / 4) % 256;
        pend_chk  = (ws == 4'h0);
        pend_data = ref_mem[w];
        for (int b = 0; b < 4; b++) if (ws[b]) ref_mem[w][8*b +: 8] = wd[8*b +: 8];
      end
    end
    if (!iv || ef) streak = 0;
    else if (ed) streak = (streak < STARVE_MAX) ? streak + 1 : STARVE_MAX;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 16'd0, 4'h0, 32'd0, 16'd0);
  endtask

  initial begin
    logic [3:0] strb_set [8];
    strb_set[0] = 4'h0; strb_set[1] = 4'hF; strb_set[2] = 4'h1; strb_set[3] = 4'h2;
    strb_set[4] = 4'h4; strb_set[5] = 4'h8; strb_set[6] = 4'h3; strb_set[7] = 4'hC;
    for (int k = 0; k < 256; k++) ref_mem[k] = init_word(k);
    streak = 0; pend_own = 0; pend_chk = 1'b0; pend_data = 32'd0; pend_err = 1'b0;
    exp_i_hold = 32'd0;

    ck_rst = 1'b0;
    d_req_valid = 1'b1; d_req_addr = 16'h0100; d_req_wstrb = 4'h0; d_req_wdata = 32'd0;
    i_req_valid = 1'b1; i_req_addr = 16'h0040;
    repeat (3) @(negedge clk);
    chk("rst_d_ready", {31'd0, d_req_ready}, 32'd0);
    chk("rst_i_ready", {31'd0, i_req_ready}, 32'd0);
    chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
    chk("rst_ram_we", {28'd0, ram_we}, 32'd0);
    chk("rst_d_resp_valid", {31'd0, d_resp_valid}, 32'd0);
    chk("rst_i_resp_valid", {31'd0, i_resp_valid}, 32'd0);
    chk("rst_err", {31'd0, err_misalign}, 32'd0);
    d_req_valid = 1'b0; i_req_valid = 1'b0;
    ck_rst = 1'b1;

    // Fetch only.
    cycle(1'b0, 1'b1, 16'd0, 4'h0, 32'd0, 16'h0040);
    idle();
    chk("fetch_word", i_resp_rdata, 32'h0050_0093);
    chk("fetch_no_d", {31'd0, d_resp_valid}, 32'd0);

    // Store then load, then byte store then load.
    cycle(1'b1, 1'b0, 16'h0100, 4'hF, 32'hDEAD_BEEF, 16'd0);
    cycle(1'b1, 1'b0, 16'h0100, 4'h0, 32'd0, 16'd0);
    idle();
    chk("load_after_store", d_resp_rdata, 32'hDEAD_BEEF);
    cycle(1'b1, 1'b0, 16'h0100, 4'h2, 32'h0000_AA00, 16'd0);
    cycle(1'b1, 1'b0, 16'h0100, 4'h0, 32'd0, 16'd0);
    idle();
    chk("byte_store", d_resp_rdata, 32'hDEAD_AAEF);

    // Contention: D,D,D,D,I repeating.
    for (int k = 0; k < 15; k++) begin
      cycle(1'b1, 1'b1, 16'h0100, 4'h0, 32'd0, 16'h0040);
      chk("contend_i_grant", {31'd0, i_req_ready}, {31'd0, (k % 5) == 4});
      chk("contend_d_grant", {31'd0, d_req_ready}, {31'd0, (k % 5) != 4});
    end
    idle();

    // Misaligned read at 0x102.
    cycle(1'b1, 1'b0, 16'h0102, 4'h0, 32'd0, 16'd0);
`ifdef MEM_ARBITER_ALIGN_CHECK_EN
    chk("misalign_ram_en", {31'd0, ram_en}, 32'd0);
    idle();
    chk("misalign_err", {31'd0, err_misalign}, 32'd1);
    chk("misalign_rdata", d_resp_rdata, 32'd0);
`else
    chk("misalign_ram_en", {31'd0, ram_en}, 32'd1);
    idle();
    chk("misalign_err", {31'd0, err_misalign}, 32'd0);
    chk("misalign_rdata", d_resp_rdata, 32'hDEAD_AAEF);
`endif
    chk("misalign_valid", {31'd0, d_resp_valid}, 32'd1);
    idle();

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
            16'($urandom_range(0, 255) * 4), strb_set[$urandom_range(0, 7)], $urandom(),
            16'($urandom_range(0, 255) * 4));
    end
    idle();

    // Reset while a data read response is in flight.
    cycle(1'b1, 1'b0, 16'h0100, 4'h0, 32'd0, 16'd0);
    i_req_valid = 1'b1;
    @(posedge clk);
    #2 ck_rst = 1'b0;
    #1;
    chk("midrst_d_resp_valid", {31'd0, d_resp_valid}, 32'd0);
    chk("midrst_i_resp_valid", {31'd0, i_resp_valid}, 32'd0);
    chk("midrst_d_ready", {31'd0, d_req_ready}, 32'd0);
    chk("midrst_i_ready", {31'd0, i_req_ready}, 32'd0);
    chk("midrst_ram_en", {31'd0, ram_en}, 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("midrst_hold_d_resp_valid", {31'd0, d_resp_valid}, 32'd0);
    chk("midrst_hold_ram_we", {28'd0, ram_we}, 32'd0);
    @(negedge clk);
    d_req_valid = 1'b0; i_req_valid = 1'b0;
    ck_rst = 1'b1;
    pend_own = 0; pend_chk = 1'b0; pend_err = 1'b0; streak = 0; exp_i_hold = 32'd0;
    cycle(1'b1, 1'b0, 16'h0100, 4'h0, 32'd0, 16'd0);
    idle();
    chk("post_rst_load", d_resp_rdata, ref_mem[64]);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port, synchronous-read instruction/data BRAM between the CPU fetch port and the load/store port.
- Sits between the core and the BRAM inside z1top.
- Data accesses take fixed priority; a starvation counter guarantees fetch forward progress.
- Every accepted request gets exactly one response pulse one cycle later, routed to its owner.

Parameters:
- ADDR_W, 16, byte-address width of both request ports.
- DATA_W, 32, data width (fixed at 32; the strobe logic assumes 4 bytes).
- STARVE_MAX, 4, number of consecutive data grants, with fetch pending, after which fetch wins once.

Ports:
- clk  in  1  system clock (100 MHz).
- ck_rst  in  1  asynchronous, active-low reset.
- d_req_valid  in  1  load/store request valid.
- d_req_ready  out  1  load/store request accepted this cycle.
- d_req_addr  in  ADDR_W  load/store byte address.
- d_req_wstrb  in  4  byte write strobes; 4'h0 = read.
- d_req_wdata  in  32  store data.
- d_resp_valid  out  1  load/store response pulse.
- d_resp_rdata  out  32  load data.
- i_req_valid  in  1  fetch request valid.
- i_req_ready  out  1  fetch accepted.
- i_req_addr  in  ADDR_W  fetch byte address.
- i_resp_valid  out  1  fetch response pulse.
- i_resp_rdata  out  32  instruction word.
- ram_en  out  1  BRAM enable.
- ram_we  out  4  BRAM byte write enables.
- ram_addr  out  ADDR_W-2  BRAM word address.
- ram_wdata  out  32  BRAM write data.
- ram_rdata  in  32  BRAM read data, valid one cycle after ram_en.
- err_misalign  out  1  misaligned data access pulse.

Behaviour:
- Reset (ck_rst low, asynchronous):
  - resp_owner = NONE, starve_cnt = 0.
  - All *_valid, err_misalign, ram_en and ram_we are 0.
  - Both *_ready outputs are forced to 0 while ck_rst is low.
- Arbitration (combinational, every cycle):
  - Fetch wins when i_req_valid && (!d_req_valid || starve_cnt == STARVE_MAX).
  - Otherwise data wins when d_req_valid.
  - Only the winner's ready is asserted; there is never a cycle with both readies high.
  - A handshake fires on valid && ready.
- RAM drive:
  - ram_en = fire.
  - ram_addr = winner_addr[ADDR_W-1:2].
  - ram_we = d_req_wstrb on a data fire, 0 otherwise.
  - ram_wdata = d_req_wdata.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) when data fires while i_req_valid is high.
  - Clears to 0 when fetch fires, or when i_req_valid is low.
- Response pipeline:
  - resp_owner register takes D, I or NONE on each cycle's fire.
  - In the next cycle, the owner's resp_valid pulses for 1 cycle and its rdata = ram_rdata.
  - The non-owner's rdata holds its last value.
- Latency and throughput:
  - Latency is exactly 1 cycle after the handshake.
  - Back-to-back grants are allowed; throughput is 1 request per cycle.
  - There is no response back-pressure: requesters must accept responses.
- Writes: also produce d_resp_valid; rdata is don't-care.
- Simultaneous requests:
  - Data first.
  - After STARVE_MAX consecutive data wins, fetch gets the very next cycle; the counter then clears.
- Reset mid-flight: an in-flight response is dropped; no resp_valid follows deassertion of reset.
- Idle: a cycle with no fire sets resp_owner = NONE, so no response pulses in the next cycle.

Optional Feature:
- Macro: MEM_ARBITER_ALIGN_CHECK_EN.
- With the macro:
  - A data read, or a write with wstrb = 4'hF, and addr[1:0] != 0, is misaligned.
  - A halfword strobe (4'h3 or 4'hC) with addr[0] = 1 is also misaligned.
  - A misaligned access is accepted (ready = 1) but ram_en stays 0.
  - Next cycle: d_resp_valid = 1, d_resp_rdata = 0, err_misalign = 1 for one cycle.
  - A misaligned access counts as a data win for starve_cnt.
- Without the macro: addr[1:0] is ignored and err_misalign is tied 0.

Decomposition:
- Package mem_arbiter_pkg:
  - owner_t enum: OWN_NONE, OWN_D, OWN_I.
  - WSTRB_READ = 4'h0.
  - WSTRB_WORD = 4'hF.
- Sub-module mem_arbiter_starve_ctr: saturating counter with inc/clr inputs and a sat output.

Test Plan:
- Fetch only:
  - Stimulus: BRAM preloaded word[0x10] = 0x00500093; i_req at addr 0x40.
  - Response: i_req_ready same cycle; i_resp_valid next cycle with 0x00500093; d_resp_valid stays 0.
- Store then load:
  - Stimulus: d write 0xDEADBEEF, wstrb F, to addr 0x100; next cycle d read of 0x100.
  - Response: two d_resp_valid pulses; the second carries 0xDEADBEEF.
- Byte store:
  - Stimulus: wstrb 4'h2, wdata 0x0000AA00 to 0x100, then read 0x100.
  - Response: 0xDEADAAEF.
- Contention:
  - Stimulus: d_req_valid and i_req_valid held high continuously, STARVE_MAX = 4.
  - Response: grant pattern D,D,D,D,I repeating; no cycle with both readies high.
- Reset mid-flight:
  - Stimulus: pull ck_rst low, asynchronously, one cycle after a d read fires.
  - Response: no d_resp_valid; all outputs 0 while reset is asserted; first request after release serviced normally.
- Align check (macro defined):
  - Stimulus: d read at 0x102.
  - Response: ram_en stays 0; next cycle d_resp_valid = 1, d_resp_rdata = 0, err_misalign = 1.
  - Without the macro: the same access returns word 0x100 and err_misalign stays 0.
